// File: rtl/apbs2ahblm.sv
// APB slave to AHB-lite master bridge: one AHB single transfer per APB access, PREADY wait-states until done.
// Latency 3 cycles setup->PREADY minimum; HREADY low stretches ADDR/DATA. Optional error path: APBS2AHBLM_ERR_EN.
module apbs2ahblm #(
    parameter logic [2:0] HSIZE_VAL = 3'b010
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
`ifdef APBS2AHBLM_ERR_EN
    input  logic        HRESP,
    output logic        PSLVERR,
`endif
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] hwdata_q;
    logic [1:0]  htrans_q;
    logic [31:0] prdata_q;
    logic        pready_q;
`ifdef APBS2AHBLM_ERR_EN
    logic        err_q;
    logic        pslverr_q;
    logic        err_now;

    // Error seen in an earlier wait cycle or in the completing cycle itself.
    assign err_now = err_q | HRESP;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            hwdata_q  <= '0;
            htrans_q  <= TRANS_IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
`ifdef APBS2AHBLM_ERR_EN
            err_q     <= 1'b0;
            pslverr_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q <= 1'b0;
                    // Only a setup phase starts a transfer; a stale access phase is ignored.
                    if (PSEL && !PENABLE) begin
                        addr_q   <= PADDR;
                        write_q  <= PWRITE;
                        wdata_q  <= PWDATA;
                        htrans_q <= TRANS_NONSEQ;
                        state_q  <= ST_ADDR;
`ifdef APBS2AHBLM_ERR_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= TRANS_IDLE;
                        hwdata_q <= wdata_q;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
`ifdef APBS2AHBLM_ERR_EN
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end
                    if (HREADY) begin
                        if (!write_q && !err_now) begin
                            prdata_q <= HRDATA;
                        end
                        pslverr_q <= err_now;
                        pready_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end
`else
                    if (HREADY) begin
                        if (!write_q) begin
                            prdata_q <= HRDATA;
                        end
                        pready_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    pready_q  <= 1'b0;
`ifdef APBS2AHBLM_ERR_EN
                    pslverr_q <= 1'b0;
`endif
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign HADDR  = addr_q;
    assign HWRITE = write_q;
    assign HWDATA = hwdata_q;
    assign HTRANS = htrans_q;
    assign HSIZE  = HSIZE_VAL;
    assign PRDATA = prdata_q;
    assign PREADY = pready_q;
`ifdef APBS2AHBLM_ERR_EN
    assign PSLVERR = pslverr_q;
`endif

endmodule

// File: tb/tb_apbs2ahblm.sv
// Directed bench for apbs2ahblm: per-cycle vector table plus reset-in-DATA and error sequences.
module tb_apbs2ahblm;

    logic        HCLK;
    logic        HRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
`ifdef APBS2AHBLM_ERR_EN
    logic        HRESP;
    logic        PSLVERR;
`endif

    int checks = 0;
    int errors = 0;

    apbs2ahblm #(.HSIZE_VAL(3'b010)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HSIZE   (HSIZE),
        .HWDATA  (HWDATA),
`ifdef APBS2AHBLM_ERR_EN
        .HRESP   (HRESP),
        .PSLVERR (PSLVERR),
`endif
        .HREADY  (HREADY),
        .HRDATA  (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        psel;
        logic        pen;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hready;
        logic [31:0] hrdata;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic [31:0] e_hwdata;
        logic        e_pready;
        logic [31:0] e_prdata;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic psel, input logic pen, input logic pwr,
                                input logic [31:0] paddr, input logic [31:0] pwdata,
                                input logic hready, input logic [31:0] hrdata,
                                input logic [1:0] e_htrans, input logic [31:0] e_haddr,
                                input logic e_hwrite, input logic [31:0] e_hwdata,
                                input logic e_pready, input logic [31:0] e_prdata);
        vec_t v;
        v.psel = psel; v.pen = pen; v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata;
        v.hready = hready; v.hrdata = hrdata;
        v.e_htrans = e_htrans; v.e_haddr = e_haddr; v.e_hwrite = e_hwrite;
        v.e_hwdata = e_hwdata; v.e_pready = e_pready; v.e_prdata = e_prdata;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive_cycle(input logic psel, input logic pen, input logic pwr,
                               input logic [31:0] paddr, input logic [31:0] pwdata,
                               input logic hready, input logic [31:0] hrdata);
        @(negedge HCLK);
        PSEL = psel; PENABLE = pen; PWRITE = pwr; PADDR = paddr; PWDATA = pwdata;
        HREADY = hready; HRDATA = hrdata;
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        HREADY = 1'b1; HRDATA = '0;
`ifdef APBS2AHBLM_ERR_EN
        HRESP = 1'b0;
`endif

        //          psel pen pwr paddr         pwdata        hrdy hrdata        | htrans haddr        hwr hwdata        prdy prdata
        vecs[0]  = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(1, 0, 1, 32'h4000_0010, 32'hDEAD_BEEF, 1, 32'h0,         2'b00, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[2]  = mk(1, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF, 1, 32'h0,         2'b10, 32'h4000_0010, 1, 32'h0,         0, 32'h0);
        vecs[3]  = mk(1, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF, 1, 32'h0,         2'b00, 32'h4000_0010, 1, 32'hDEAD_BEEF, 0, 32'h0);
        vecs[4]  = mk(1, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF, 1, 32'h0,         2'b00, 32'h4000_0010, 1, 32'hDEAD_BEEF, 1, 32'h0);
        vecs[5]  = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0010, 1, 32'hDEAD_BEEF, 0, 32'h0);
        // Read, HREADY low for three DATA cycles
        vecs[6]  = mk(1, 0, 0, 32'h4000_0020, 32'h1111_1111, 1, 32'h0,         2'b00, 32'h4000_0010, 1, 32'hDEAD_BEEF, 0, 32'h0);
        vecs[7]  = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 1, 32'h0,         2'b10, 32'h4000_0020, 0, 32'hDEAD_BEEF, 0, 32'h0);
        vecs[8]  = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 0, 32'hFFFF_FFFF, 2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h0);
        vecs[9]  = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 0, 32'hFFFF_FFFF, 2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h0);
        vecs[10] = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 0, 32'hFFFF_FFFF, 2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h0);
        vecs[11] = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 1, 32'h1234_5678, 2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h0);
        vecs[12] = mk(1, 1, 0, 32'h4000_0020, 32'h1111_1111, 1, 32'h0,         2'b00, 32'h4000_0020, 0, 32'h1111_1111, 1, 32'h1234_5678);
        vecs[13] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h1234_5678);
        // Write with a two-cycle address-phase stall
        vecs[14] = mk(1, 0, 1, 32'h4000_0030, 32'hCAFE_F00D, 1, 32'h0,         2'b00, 32'h4000_0020, 0, 32'h1111_1111, 0, 32'h1234_5678);
        vecs[15] = mk(1, 1, 1, 32'h4000_0030, 32'hCAFE_F00D, 0, 32'h0,         2'b10, 32'h4000_0030, 1, 32'h1111_1111, 0, 32'h1234_5678);
        vecs[16] = mk(1, 1, 1, 32'h4000_0030, 32'hCAFE_F00D, 0, 32'h0,         2'b10, 32'h4000_0030, 1, 32'h1111_1111, 0, 32'h1234_5678);
        vecs[17] = mk(1, 1, 1, 32'h4000_0030, 32'hCAFE_F00D, 1, 32'h0,         2'b10, 32'h4000_0030, 1, 32'h1111_1111, 0, 32'h1234_5678);
        vecs[18] = mk(1, 1, 1, 32'h4000_0030, 32'hCAFE_F00D, 1, 32'h0BAD_BAD0, 2'b00, 32'h4000_0030, 1, 32'hCAFE_F00D, 0, 32'h1234_5678);
        vecs[19] = mk(1, 1, 1, 32'h4000_0030, 32'hCAFE_F00D, 1, 32'h0BAD_BAD0, 2'b00, 32'h4000_0030, 1, 32'hCAFE_F00D, 1, 32'h1234_5678);
        // Back-to-back read, setup in the cycle right after DONE
        vecs[20] = mk(1, 0, 0, 32'h4000_0040, 32'h0,         1, 32'h0,         2'b00, 32'h4000_0030, 1, 32'hCAFE_F00D, 0, 32'h1234_5678);
        vecs[21] = mk(1, 1, 0, 32'h4000_0040, 32'h0,         1, 32'h0,         2'b10, 32'h4000_0040, 0, 32'hCAFE_F00D, 0, 32'h1234_5678);
        vecs[22] = mk(1, 1, 0, 32'h4000_0040, 32'h0,         1, 32'h9ABC_DEF0, 2'b00, 32'h4000_0040, 0, 32'h0,         0, 32'h1234_5678);
        vecs[23] = mk(1, 1, 0, 32'h4000_0040, 32'h0,         1, 32'h0,         2'b00, 32'h4000_0040, 0, 32'h0,         1, 32'h9ABC_DEF0);
        // Access phase seen in IDLE is ignored
        vecs[24] = mk(1, 1, 1, 32'h4000_0060, 32'h7777_7777, 1, 32'h0,         2'b00, 32'h4000_0040, 0, 32'h0,         0, 32'h9ABC_DEF0);
        vecs[25] = mk(1, 1, 1, 32'h4000_0060, 32'h7777_7777, 1, 32'h0,         2'b00, 32'h4000_0040, 0, 32'h0,         0, 32'h9ABC_DEF0);
        // PSEL dropped after setup: transfer still completes, nothing restarts
        vecs[26] = mk(1, 0, 1, 32'h4000_0050, 32'h55AA_55AA, 1, 32'h0,         2'b00, 32'h4000_0040, 0, 32'h0,         0, 32'h9ABC_DEF0);
        vecs[27] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b10, 32'h4000_0050, 1, 32'h0,         0, 32'h9ABC_DEF0);
        vecs[28] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0050, 1, 32'h55AA_55AA, 0, 32'h9ABC_DEF0);
        vecs[29] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0050, 1, 32'h55AA_55AA, 1, 32'h9ABC_DEF0);
        vecs[30] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0050, 1, 32'h55AA_55AA, 0, 32'h9ABC_DEF0);
        vecs[31] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         2'b00, 32'h4000_0050, 1, 32'h55AA_55AA, 0, 32'h9ABC_DEF0);

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive_cycle(vecs[i].psel, vecs[i].pen, vecs[i].pwr, vecs[i].paddr, vecs[i].pwdata,
                        vecs[i].hready, vecs[i].hrdata);
            chk("htrans", i, {30'h0, HTRANS}, {30'h0, vecs[i].e_htrans});
            chk("haddr",  i, HADDR,           vecs[i].e_haddr);
            chk("hwrite", i, {31'h0, HWRITE}, {31'h0, vecs[i].e_hwrite});
            chk("hwdata", i, HWDATA,          vecs[i].e_hwdata);
            chk("pready", i, {31'h0, PREADY}, {31'h0, vecs[i].e_pready});
            chk("prdata", i, PRDATA,          vecs[i].e_prdata);
            chk("hsize",  i, {29'h0, HSIZE},  32'h2);
`ifdef APBS2AHBLM_ERR_EN
            chk("pslverr", i, {31'h0, PSLVERR}, 32'h0);
`endif
        end

        // Asynchronous reset while the bridge sits in DATA
        drive_cycle(1, 0, 0, 32'h4000_0080, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_0080, 32'h0, 1, 32'h0);
        chk("rst_pre_htrans", 0, {30'h0, HTRANS}, 32'h2);
        drive_cycle(1, 1, 0, 32'h4000_0080, 32'h0, 0, 32'h0);
        #1 HRESETn = 1'b0;
        #1;
        chk("rst_htrans", 0, {30'h0, HTRANS}, 32'h0);
        chk("rst_pready", 0, {31'h0, PREADY}, 32'h0);
        chk("rst_prdata", 0, PRDATA, 32'h0);
        chk("rst_haddr",  0, HADDR, 32'h0);
        chk("rst_hwdata", 0, HWDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive_cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        drive_cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("post_rst_idle", 0, {30'h0, HTRANS}, 32'h0);
        drive_cycle(1, 0, 0, 32'h4000_0090, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_0090, 32'h0, 1, 32'h0);
        chk("post_rst_htrans", 0, {30'h0, HTRANS}, 32'h2);
        chk("post_rst_haddr",  0, HADDR, 32'h4000_0090);
        drive_cycle(1, 1, 0, 32'h4000_0090, 32'h0, 1, 32'h1357_2468);
        chk("post_rst_pready_data", 0, {31'h0, PREADY}, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_0090, 32'h0, 1, 32'h0);
        chk("post_rst_pready", 0, {31'h0, PREADY}, 32'h1);
        chk("post_rst_prdata", 0, PRDATA, 32'h1357_2468);
        drive_cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("post_rst_done", 0, {31'h0, PREADY}, 32'h0);

`ifdef APBS2AHBLM_ERR_EN
        // Two-cycle error response on a read, then a clean read
        drive_cycle(1, 0, 0, 32'h4000_00A0, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_00A0, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_00A0, 32'h0, 0, 32'h7777_7777);
        HRESP = 1'b1;
        drive_cycle(1, 1, 0, 32'h4000_00A0, 32'h0, 1, 32'h7777_7777);
        chk("err_pslverr_data", 0, {31'h0, PSLVERR}, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_00A0, 32'h0, 1, 32'h0);
        HRESP = 1'b0;
        chk("err_pready",  0, {31'h0, PREADY}, 32'h1);
        chk("err_pslverr", 0, {31'h0, PSLVERR}, 32'h1);
        chk("err_prdata",  0, PRDATA, 32'h1357_2468);
        drive_cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("err_pslverr_idle", 0, {31'h0, PSLVERR}, 32'h0);
        drive_cycle(1, 0, 0, 32'h4000_00B0, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_00B0, 32'h0, 1, 32'h0);
        drive_cycle(1, 1, 0, 32'h4000_00B0, 32'h0, 1, 32'h2468_ACE0);
        drive_cycle(1, 1, 0, 32'h4000_00B0, 32'h0, 1, 32'h0);
        chk("ok_pready",  0, {31'h0, PREADY}, 32'h1);
        chk("ok_pslverr", 0, {31'h0, PSLVERR}, 32'h0);
        chk("ok_prdata",  0, PRDATA, 32'h2468_ACE0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
